// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared encodings and defaults for the 68000 bus arbiter.
package m68k_bus_arbiter_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_END = 3'd1;
  localparam logic [2:0] ST_GRANT    = 3'd2;
  localparam logic [2:0] ST_DMA      = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int DEF_REARB_GAP     = 2;

  // One counter width serves both the grant timeout and the re-arbitration gap.
  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/m68k_bus_arbiter_edge_sync.sv
// N-stage synchroniser with rise/fall pulses; sync_reg[0] is the newest sample.
module c7m_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) sync_reg <= {STAGES{INIT}};
    else      sync_reg <= {sync_reg[STAGES-2:0], d};
  end

  assign q    = sync_reg[STAGES-1];
  assign fall = sync_reg[STAGES-1] & ~sync_reg[STAGES-2];
  assign rise = ~sync_reg[STAGES-1] & sync_reg[STAGES-2];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Three-wire 68000 bus arbitration between the Pi sequencer (default master)
// and external DMA masters, stepped on synchronised c7m falling edges.
module m68k_bus_arbiter
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int REARB_GAP     = DEF_REARB_GAP,
  parameter int CNT_W         = 8
) (
  input  logic             c200m,
  input  logic             reset_out,
  input  logic             M68K_CLK,
  input  logic             M68K_BR_n,
  input  logic             M68K_BGACK_n,
  input  logic             txn_active,
  input  logic             op_req,
  input  logic             clr_timeout,
  output logic             M68K_BG_n,
  output logic             pi_hold,
  output logic             dma_active,
  output logic             timeout_sticky,
  output logic [CNT_W-1:0] grant_count
);

  localparam int TW = cnt_bits(GRANT_TIMEOUT, REARB_GAP);
  localparam logic [TW-1:0]    TMO_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0]    GAP_LOAD = TW'(REARB_GAP);
  localparam logic [TW-1:0]    ONE      = TW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic c7m_fall, br_s, bgack_s;
  logic clk_q, clk_rise, br_rise, br_fall, bgack_rise, bgack_fall;
  logic unused_edges;

  c7m_edge_sync #(.STAGES(3), .INIT(1'b0)) u_clk_sync (
    .clk(c200m), .srst(reset_out), .d(M68K_CLK),
    .q(clk_q), .rise(clk_rise), .fall(c7m_fall)
  );
  c7m_edge_sync #(.STAGES(2), .INIT(1'b1)) u_br_sync (
    .clk(c200m), .srst(reset_out), .d(M68K_BR_n),
    .q(br_s), .rise(br_rise), .fall(br_fall)
  );
  c7m_edge_sync #(.STAGES(2), .INIT(1'b1)) u_bgack_sync (
    .clk(c200m), .srst(reset_out), .d(M68K_BGACK_n),
    .q(bgack_s), .rise(bgack_rise), .fall(bgack_fall)
  );

  // op_req is gated by pi_hold inside the sequencer, not here.
  assign unused_edges = &{1'b0, clk_q, clk_rise, br_rise, br_fall, bgack_rise, bgack_fall, op_req};

  logic [2:0]       state_reg, state_next;
  logic             bg_n_reg, bg_n_next;
  logic             pi_hold_reg, pi_hold_next;
  logic             dma_reg, dma_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] grant_count_reg, grant_count_next;
  logic [TW-1:0]    tmo_reg, tmo_next;
  logic [TW-1:0]    gap_reg, gap_next;
  logic             tmo_set;

  always_comb begin
    state_next       = state_reg;
    bg_n_next        = bg_n_reg;
    pi_hold_next     = pi_hold_reg;
    dma_next         = dma_reg;
    grant_count_next = grant_count_reg;
    tmo_next         = tmo_reg;
    gap_next         = gap_reg;
    tmo_set          = 1'b0;
    if (c7m_fall) begin
      case (state_reg)
        ST_IDLE: begin
          if (!br_s) begin
            state_next   = ST_WAIT_END;
            pi_hold_next = 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (br_s) begin
            state_next   = ST_IDLE;
            pi_hold_next = 1'b0;
          end else if (!txn_active) begin
            state_next = ST_GRANT;
            bg_n_next  = 1'b0;
            tmo_next   = '0;
            if (grant_count_reg != CNT_MAX) grant_count_next = grant_count_reg + 1'b1;
          end
        end
        ST_GRANT: begin
          // BGACK beats withdrawal, withdrawal beats timeout.
          if (!bgack_s) begin
            state_next = ST_DMA;
            bg_n_next  = 1'b1;
            dma_next   = 1'b1;
          end else if (br_s || tmo_reg == TMO_LAST) begin
            state_next   = ST_IDLE;
            bg_n_next    = 1'b1;
            pi_hold_next = 1'b0;
            tmo_set      = !br_s;
          end else begin
            tmo_next = tmo_reg + ONE;
          end
        end
        ST_DMA: begin
          if (bgack_s) begin
            state_next = ST_RELEASE;
            dma_next   = 1'b0;
            gap_next   = GAP_LOAD;
          end
        end
        ST_RELEASE: begin
          if (gap_reg <= ONE) begin
            // A request pending at gap expiry skips IDLE; pi_hold stays high.
            if (!br_s) begin
              state_next = ST_WAIT_END;
            end else begin
              state_next   = ST_IDLE;
              pi_hold_next = 1'b0;
            end
          end else begin
            gap_next = gap_reg - ONE;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          bg_n_next    = 1'b1;
          pi_hold_next = 1'b0;
          dma_next     = 1'b0;
        end
      endcase
    end
    timeout_next = tmo_set ? 1'b1 : (clr_timeout ? 1'b0 : timeout_reg);
  end

  always_ff @(posedge c200m) begin
    if (reset_out) begin
      state_reg       <= ST_IDLE;
      bg_n_reg        <= 1'b1;
      pi_hold_reg     <= 1'b0;
      dma_reg         <= 1'b0;
      timeout_reg     <= 1'b0;
      grant_count_reg <= '0;
      tmo_reg         <= '0;
      gap_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      bg_n_reg        <= bg_n_next;
      pi_hold_reg     <= pi_hold_next;
      dma_reg         <= dma_next;
      timeout_reg     <= timeout_next;
      grant_count_reg <= grant_count_next;
      tmo_reg         <= tmo_next;
      gap_reg         <= gap_next;
    end
  end

  assign M68K_BG_n      = bg_n_reg;
  assign pi_hold        = pi_hold_reg;
  assign dma_active     = dma_reg;
  assign timeout_sticky = timeout_reg;
  assign grant_count    = grant_count_reg;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter; checks are sampled shortly after each c7m fall is processed.
module tb_m68k_bus_arbiter;

  logic       c200m = 1'b0;
  logic       reset_out = 1'b1;
  logic       M68K_CLK = 1'b0;
  logic       M68K_BR_n = 1'b1;
  logic       M68K_BGACK_n = 1'b1;
  logic       txn_active = 1'b0;
  logic       op_req = 1'b0;
  logic       clr_timeout = 1'b0;
  logic       M68K_BG_n;
  logic       pi_hold;
  logic       dma_active;
  logic       timeout_sticky;
  logic [7:0] grant_count;

  int tests_run = 0;
  int failed = 0;

  m68k_bus_arbiter #(.GRANT_TIMEOUT(16), .REARB_GAP(2), .CNT_W(8)) dut (
    .c200m(c200m), .reset_out(reset_out), .M68K_CLK(M68K_CLK),
    .M68K_BR_n(M68K_BR_n), .M68K_BGACK_n(M68K_BGACK_n),
    .txn_active(txn_active), .op_req(op_req), .clr_timeout(clr_timeout),
    .M68K_BG_n(M68K_BG_n), .pi_hold(pi_hold), .dma_active(dma_active),
    .timeout_sticky(timeout_sticky), .grant_count(grant_count)
  );

  initial forever #5 c200m = ~c200m;
  initial forever #60 M68K_CLK = ~M68K_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Wait n c7m falls; return once the arbiter's registered update for the last one is visible.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge M68K_CLK);
      repeat (4) @(posedge c200m);
      #1;
    end
  endtask

  task automatic test_reset;
    reset_out = 1'b1;
    repeat (4) @(posedge c200m);
    #1;
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL reset_bg_n: got %b want 1", M68K_BG_n); end
    tests_run++; if (pi_hold !== 1'b0) begin failed++; $display("FAIL reset_pi_hold: got %b want 0", pi_hold); end
    tests_run++; if (dma_active !== 1'b0) begin failed++; $display("FAIL reset_dma_active: got %b want 0", dma_active); end
    tests_run++; if (timeout_sticky !== 1'b0) begin failed++; $display("FAIL reset_timeout: got %b want 0", timeout_sticky); end
    tests_run++; if (grant_count !== 8'd0) begin failed++; $display("FAIL reset_grant_count: got %0d want 0", grant_count); end
    reset_out = 1'b0;
    step(2);
    tests_run++; if (pi_hold !== 1'b0) begin failed++; $display("FAIL reset_idle_hold: got %b want 0", pi_hold); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_idle_grant;
    M68K_BR_n = 1'b0;
    step(1);
    tests_run++; if (pi_hold !== 1'b1) begin failed++; $display("FAIL idle_hold_rise: got %b want 1", pi_hold); end
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL idle_bg_early: got %b want 1", M68K_BG_n); end
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b0) begin failed++; $display("FAIL idle_bg_grant: got %b want 0", M68K_BG_n); end
    tests_run++; if (grant_count !== 8'd1) begin failed++; $display("FAIL idle_grant_count: got %0d want 1", grant_count); end
    M68K_BR_n = 1'b1;
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL withdraw_bg: got %b want 1", M68K_BG_n); end
    tests_run++; if (pi_hold !== 1'b0) begin failed++; $display("FAIL withdraw_hold: got %b want 0", pi_hold); end
    tests_run++; if (timeout_sticky !== 1'b0) begin failed++; $display("FAIL withdraw_timeout: got %b want 0", timeout_sticky); end
    $display("[TB] test_idle_grant done");
  endtask

  task automatic test_in_flight;
    txn_active = 1'b1;
    op_req = 1'b1;
    M68K_BR_n = 1'b0;
    step(1);
    tests_run++; if (pi_hold !== 1'b1) begin failed++; $display("FAIL inflight_hold: got %b want 1", pi_hold); end
    for (int i = 0; i < 5; i++) begin
      step(1);
      tests_run++; if (M68K_BG_n !== 1'b1 || pi_hold !== 1'b1) begin failed++; $display("FAIL inflight_wait%0d: got bg_n=%b hold=%b want bg_n=1 hold=1", i, M68K_BG_n, pi_hold); end
    end
    txn_active = 1'b0;
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b0) begin failed++; $display("FAIL inflight_grant: got %b want 0", M68K_BG_n); end
    tests_run++; if (grant_count !== 8'd2) begin failed++; $display("FAIL inflight_count: got %0d want 2", grant_count); end
    M68K_BR_n = 1'b1;
    op_req = 1'b0;
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL inflight_release: got %b want 1", M68K_BG_n); end
    $display("[TB] test_in_flight done");
  endtask

  task automatic test_full_dma;
    M68K_BR_n = 1'b0;
    step(2);
    tests_run++; if (M68K_BG_n !== 1'b0 || grant_count !== 8'd3) begin failed++; $display("FAIL dma_grant: got bg_n=%b count=%0d want bg_n=0 count=3", M68K_BG_n, grant_count); end
    step(3);
    tests_run++; if (M68K_BG_n !== 1'b0) begin failed++; $display("FAIL dma_grant_hold: got %b want 0", M68K_BG_n); end
    M68K_BGACK_n = 1'b0;
    M68K_BR_n = 1'b1;
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL dma_bg_negate: got %b want 1", M68K_BG_n); end
    tests_run++; if (dma_active !== 1'b1 || pi_hold !== 1'b1) begin failed++; $display("FAIL dma_active: got dma=%b hold=%b want 1 1", dma_active, pi_hold); end
    step(2);
    tests_run++; if (dma_active !== 1'b1) begin failed++; $display("FAIL dma_stays: got %b want 1", dma_active); end
    M68K_BGACK_n = 1'b1;
    step(1);
    tests_run++; if (dma_active !== 1'b0 || pi_hold !== 1'b1) begin failed++; $display("FAIL release_entry: got dma=%b hold=%b want 0 1", dma_active, pi_hold); end
    step(1);
    tests_run++; if (pi_hold !== 1'b1) begin failed++; $display("FAIL release_gap1: got %b want 1", pi_hold); end
    step(1);
    tests_run++; if (pi_hold !== 1'b0) begin failed++; $display("FAIL release_gap2: got %b want 0", pi_hold); end
    $display("[TB] test_full_dma done");
  endtask

  task automatic test_timeout;
    M68K_BR_n = 1'b0;
    step(2);
    tests_run++; if (M68K_BG_n !== 1'b0 || grant_count !== 8'd4) begin failed++; $display("FAIL tmo_grant: got bg_n=%b count=%0d want bg_n=0 count=4", M68K_BG_n, grant_count); end
    for (int i = 1; i < 16; i++) begin
      step(1);
      tests_run++; if (M68K_BG_n !== 1'b0 || timeout_sticky !== 1'b0) begin failed++; $display("FAIL tmo_wait%0d: got bg_n=%b sticky=%b want 0 0", i, M68K_BG_n, timeout_sticky); end
    end
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b1) begin failed++; $display("FAIL tmo_bg: got %b want 1", M68K_BG_n); end
    tests_run++; if (timeout_sticky !== 1'b1) begin failed++; $display("FAIL tmo_sticky: got %b want 1", timeout_sticky); end
    M68K_BR_n = 1'b1;
    step(1);
    tests_run++; if (timeout_sticky !== 1'b1 || pi_hold !== 1'b0) begin failed++; $display("FAIL tmo_holds: got sticky=%b hold=%b want 1 0", timeout_sticky, pi_hold); end
    clr_timeout = 1'b1;
    @(posedge c200m);
    #1;
    clr_timeout = 1'b0;
    tests_run++; if (timeout_sticky !== 1'b0) begin failed++; $display("FAIL tmo_clear: got %b want 0", timeout_sticky); end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_back_to_back;
    M68K_BR_n = 1'b0;
    step(2);
    tests_run++; if (grant_count !== 8'd5) begin failed++; $display("FAIL b2b_count1: got %0d want 5", grant_count); end
    M68K_BGACK_n = 1'b0;
    step(1);
    tests_run++; if (dma_active !== 1'b1 || M68K_BG_n !== 1'b1) begin failed++; $display("FAIL b2b_dma: got dma=%b bg_n=%b want 1 1", dma_active, M68K_BG_n); end
    step(1);
    tests_run++; if (dma_active !== 1'b1 || M68K_BG_n !== 1'b1) begin failed++; $display("FAIL b2b_br_ignored: got dma=%b bg_n=%b want 1 1", dma_active, M68K_BG_n); end
    M68K_BGACK_n = 1'b1;
    step(2);
    tests_run++; if (dma_active !== 1'b0 || pi_hold !== 1'b1) begin failed++; $display("FAIL b2b_release: got dma=%b hold=%b want 0 1", dma_active, pi_hold); end
    step(1);
    tests_run++; if (pi_hold !== 1'b1 || M68K_BG_n !== 1'b1) begin failed++; $display("FAIL b2b_wait_end: got hold=%b bg_n=%b want 1 1", pi_hold, M68K_BG_n); end
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b0 || grant_count !== 8'd6) begin failed++; $display("FAIL b2b_regrant: got bg_n=%b count=%0d want 0 6", M68K_BG_n, grant_count); end
    M68K_BR_n = 1'b1;
    step(1);
    tests_run++; if (M68K_BG_n !== 1'b1 || timeout_sticky !== 1'b0) begin failed++; $display("FAIL b2b_withdraw: got bg_n=%b sticky=%b want 1 0", M68K_BG_n, timeout_sticky); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid_dma;
    M68K_BR_n = 1'b0;
    step(2);
    M68K_BGACK_n = 1'b0;
    step(1);
    tests_run++; if (dma_active !== 1'b1 || grant_count !== 8'd7) begin failed++; $display("FAIL rdma_pre: got dma=%b count=%0d want 1 7", dma_active, grant_count); end
    reset_out = 1'b1;
    @(posedge c200m);
    #1;
    tests_run++; if (M68K_BG_n !== 1'b1 || pi_hold !== 1'b0 || dma_active !== 1'b0 || grant_count !== 8'd0) begin failed++; $display("FAIL rdma_reset: got bg_n=%b hold=%b dma=%b count=%0d want 1 0 0 0", M68K_BG_n, pi_hold, dma_active, grant_count); end
    M68K_BR_n = 1'b1;
    M68K_BGACK_n = 1'b1;
    repeat (3) @(posedge c200m);
    #1;
    reset_out = 1'b0;
    step(1);
    $display("[TB] test_reset_mid_dma done");
  endtask

  task automatic test_reset_mid_grant;
    M68K_BR_n = 1'b0;
    step(2);
    tests_run++; if (M68K_BG_n !== 1'b0) begin failed++; $display("FAIL rgnt_pre: got %b want 0", M68K_BG_n); end
    reset_out = 1'b1;
    @(posedge c200m);
    #1;
    tests_run++; if (M68K_BG_n !== 1'b1 || pi_hold !== 1'b0 || grant_count !== 8'd0) begin failed++; $display("FAIL rgnt_reset: got bg_n=%b hold=%b count=%0d want 1 0 0", M68K_BG_n, pi_hold, grant_count); end
    M68K_BR_n = 1'b1;
    repeat (3) @(posedge c200m);
    #1;
    reset_out = 1'b0;
    step(1);
    $display("[TB] test_reset_mid_grant done");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      M68K_BR_n = 1'b0;
      step(2);
      M68K_BR_n = 1'b1;
      step(1);
    end
    tests_run++; if (grant_count !== 8'd255) begin failed++; $display("FAIL sat_count: got %0d want 255", grant_count); end
    tests_run++; if (M68K_BG_n !== 1'b1 || timeout_sticky !== 1'b0) begin failed++; $display("FAIL sat_idle: got bg_n=%b sticky=%b want 1 0", M68K_BG_n, timeout_sticky); end
    $display("[TB] test_saturation done");
  endtask

  initial begin
    test_reset;
    test_idle_grant;
    test_in_flight;
    test_full_dma;
    test_timeout;
    test_back_to_back;
    test_reset_mid_dma;
    test_reset_mid_grant;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Owns 68000 bus mastership for the PiStorm board.
- Implements three-wire arbitration (BR_n/BG_n/BGACK_n) between the Pi transaction sequencer, which is the default master, and external DMA masters such as Agnus or Zorro cards.
- Runs in the c200m domain and tracks c7m edges by oversampling M68K_CLK.
- Holds off new Pi transactions while an external master owns the bus, and reports arbitration status into the Pi status word.

Parameters:
- GRANT_TIMEOUT, 16: c7m cycles allowed in GRANT without BGACK_n before the grant is withdrawn.
- REARB_GAP, 2: c7m cycles after BGACK_n release before the Pi may start a transaction again.
- CNT_W, 8: width of the saturating grant counter.

Ports:
- c200m  in  1  system clock (PI_CLK).
- reset_out  in  1  synchronous, active-high reset.
- M68K_CLK  in  1  raw c7m, oversampled.
- M68K_BR_n  in  1  raw bus request from external master.
- M68K_BGACK_n  in  1  raw bus grant acknowledge.
- txn_active  in  1  sequencer state != 0 (AS_n cycle in flight).
- op_req  in  1  Pi request pending, not yet started.
- clr_timeout  in  1  one-cycle pulse; clears timeout_sticky.
- M68K_BG_n  out  1  bus grant to 68K bus.
- pi_hold  out  1  sequencer must not leave state 0 while high.
- dma_active  out  1  external master owns bus.
- timeout_sticky  out  1  a grant timed out since last clear.
- grant_count  out  CNT_W  saturating count of grants issued.

Behaviour:
- Reset:
  - M68K_BG_n=1, pi_hold=0, dma_active=0, timeout_sticky=0, grant_count=0.
  - State IDLE, all sync flops 1 (BR/BGACK) or 0 (clk).
  - Reset mid-grant releases BG_n on the next c200m edge. Resetting the 68K bus also drops DMA masters.
- Sync:
  - BR_n and BGACK_n pass through 2 flops.
  - M68K_CLK passes through 3 flops.
  - c7m_fall = sync[2] & !sync[1].
  - All state transitions happen only on c200m cycles with c7m_fall, except reset and the reset-held branch.
- IDLE:
  - BG_n=1, pi_hold=0.
  - On c7m_fall with br_s==0, go to WAIT_END and set pi_hold=1 in the same registered update.
- WAIT_END:
  - pi_hold=1.
  - On c7m_fall with txn_active==0, go to GRANT.
  - A transaction already started (txn_active=1) always completes; op_req stays pending, blocked by pi_hold.
  - If br_s returns to 1 before GRANT, go back to IDLE and clear pi_hold.
- GRANT:
  - BG_n=0; grant_count increments on entry, saturating at 2^CNT_W-1.
  - Timeout counter is cleared on entry and increments per c7m_fall.
  - bgack_s==0: go to DMA.
  - Else br_s==1 (request withdrawn): go to IDLE with BG_n=1.
  - Else counter==GRANT_TIMEOUT-1: go to IDLE and set timeout_sticky.
  - Priority order when several hold: BGACK, then withdrawal, then timeout.
- DMA:
  - BG_n=1 (negated once BGACK is seen, per the 68000 protocol), dma_active=1, pi_hold=1.
  - On c7m_fall with bgack_s==1, go to RELEASE and load the gap counter.
- RELEASE:
  - dma_active=0, pi_hold=1.
  - After REARB_GAP c7m_falls, go to IDLE.
  - If br_s==0 at the moment the gap expires, go directly to WAIT_END. txn_active is 0, so the next c7m_fall reaches GRANT.
- A BR re-asserted during DMA is ignored until RELEASE.
- clr_timeout:
  - Clears timeout_sticky.
  - If clr_timeout and timeout set coincide, set wins.
- Outputs are registered. pi_hold rises within 1 c200m cycle of the c7m_fall that samples BR.
- Counters are sized ceil(log2(max(GRANT_TIMEOUT, REARB_GAP)+1)).

Decomposition:
- pistorm_arb_defs.vh holds:
  - state encodings (IDLE=0, WAIT_END=1, GRANT=2, DMA=3, RELEASE=4; 3 bits);
  - default GRANT_TIMEOUT and REARB_GAP.
- Sub-module c7m_edge_sync: a parameterised N-stage synchroniser with rise/fall pulse outputs. It is reused for M68K_CLK, BR_n and BGACK_n.

Test Plan:
- Idle grant: BR_n low, txn_active=0 → pi_hold=1 after 1st c7m_fall; BG_n=0 after 2nd; grant_count=1.
- In-flight transaction: BR_n low while txn_active=1 for 5 c7m → BG_n stays 1 until the first c7m_fall with txn_active=0, then BG_n=0. op_req held blocked throughout.
- Full DMA:
  - BGACK_n low 3 c7m after BG_n → BG_n=1 and dma_active=1.
  - BGACK_n high → pi_hold drops exactly REARB_GAP=2 c7m_falls later.
- Timeout: BR_n low and BGACK_n never asserted → BG_n returns to 1 after 16 c7m in GRANT, timeout_sticky=1. clr_timeout pulse → 0.
- Withdrawal and back-to-back:
  - BR_n released in GRANT → IDLE next c7m_fall, no timeout.
  - BR_n held low at RELEASE expiry → straight to WAIT_END, grant_count=2.
- Reset mid-DMA: assert reset_out in DMA → next c200m edge BG_n=1, pi_hold=0, dma_active=0, grant_count=0. Saturation: 300 grants with CNT_W=8 → grant_count=255.
